// File: rtl/ram_hex_monitor.sv
// Memory probe: single-port synchronous RAM with a host handshake port and a
// built-in viewer that scans the word at view_addr onto a multiplexed hex display.
module ram_hex_monitor #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 8,
  parameter int DIGITS       = 4,
  parameter int REFRESH_BITS = 18
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_di,
  output logic                  host_ack,
  output logic [DATA_WIDTH-1:0] host_do,
  input  logic [ADDR_WIDTH-1:0] view_addr,
  input  logic                  lz_blank,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            sseg
);

  localparam int D             = DATA_WIDTH / 4;
  localparam int SEL_BITS      = $clog2(DIGITS);
  localparam int ADDR_NIB_BITS = (DIGITS - D) * 4;
  localparam int DEPTH         = 1 << ADDR_WIDTH;
  localparam logic [SEL_BITS-1:0] DP_DIGIT = SEL_BITS'(D);

  typedef enum logic [1:0] {IDLE, HOST_ACK, VIEW_CAP} state_t;

  state_t                   state;
  logic [DATA_WIDTH-1:0]    mem [DEPTH];
  logic [DATA_WIDTH-1:0]    ram_dout;
  logic                     ram_en;
  logic                     ram_we;
  logic [ADDR_WIDTH-1:0]    ram_addr;
  logic                     host_issue;
  logic                     view_issue;
  logic                     view_set;
  logic                     view_pend;
  logic [ADDR_WIDTH-1:0]    view_addr_reg;
  logic [ADDR_NIB_BITS-1:0] view_addr_nib;
  logic [ADDR_NIB_BITS-1:0] view_addr_shown;
  logic [DATA_WIDTH-1:0]    view_word;
  logic [REFRESH_BITS-1:0]  scan_cnt;
  logic [SEL_BITS-1:0]      digit_sel;
  logic [DIGITS*4-1:0]      disp_bits;
  logic [3:0]               nibble;
  logic [DIGITS-1:0]        blank;
  logic                     zero_run;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // Host wins the single RAM port; the viewer only reads when the host is quiet.
  assign host_issue = (state == IDLE) && host_req;
  assign view_issue = (state == IDLE) && !host_req && view_pend;
  assign ram_en     = host_issue || view_issue;
  assign ram_we     = host_issue && host_we && !reset;
  assign ram_addr   = host_issue ? host_addr : view_addr;
  assign view_set   = (scan_cnt == '1) || (view_addr != view_addr_reg);

  always_ff @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr] <= host_di;
        ram_dout      <= host_di;
      end else begin
        ram_dout <= mem[ram_addr];
      end
    end
  end

  // Address digits take the low nibbles of view_addr, zero-filled if it is narrow.
  if (ADDR_WIDTH >= ADDR_NIB_BITS) begin : g_addr_trunc
    assign view_addr_nib = view_addr[ADDR_NIB_BITS-1:0];
  end else begin : g_addr_ext
    assign view_addr_nib = {{(ADDR_NIB_BITS - ADDR_WIDTH){1'b0}}, view_addr};
  end

  assign digit_sel = scan_cnt[REFRESH_BITS-1 -: SEL_BITS];
  assign disp_bits = {view_addr_shown, view_word};
  assign nibble    = disp_bits[{digit_sel, 2'b00} +: 4];

  // A data digit blanks when it and every more significant data nibble are zero.
  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int k = D - 1; k >= 1; k--) begin
      zero_run = zero_run && (view_word[4*k +: 4] == 4'h0);
      blank[k] = lz_blank && zero_run;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      host_ack        <= 1'b0;
      host_do         <= '0;
      view_word       <= '0;
      view_pend       <= 1'b1;
      view_addr_reg   <= '0;
      view_addr_shown <= '0;
      scan_cnt        <= '0;
      an              <= '1;
      sseg            <= 8'hFF;
    end else begin
      scan_cnt      <= scan_cnt + REFRESH_BITS'(1);
      view_addr_reg <= view_addr;
      host_ack      <= 1'b0;
      an            <= ~(DIGITS'(1) << digit_sel);
      sseg          <= {digit_sel != DP_DIGIT, blank[digit_sel] ? 7'h7F : hex7(nibble)};
      if (view_set)
        view_pend <= 1'b1;
      else if (view_issue)
        view_pend <= 1'b0;
      case (state)
        IDLE: begin
          if (host_req) begin
            state <= HOST_ACK;
          end else if (view_pend) begin
            state           <= VIEW_CAP;
            view_addr_shown <= view_addr_nib;
          end
        end
        HOST_ACK: begin
          host_ack <= 1'b1;
          host_do  <= ram_dout;
          state    <= IDLE;
        end
        VIEW_CAP: begin
          view_word <= ram_dout;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_hex_monitor.sv
// Directed bench for ram_hex_monitor: host handshake, write-first readback,
// display scan, leading-zero blanking and reset during a write.
module tb_ram_hex_monitor;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int ND = 4;

  logic          clk;
  logic          reset;
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_di;
  logic          host_ack;
  logic [DW-1:0] host_do;
  logic [AW-1:0] view_addr;
  logic          lz_blank;
  logic [ND-1:0] an;
  logic [7:0]    sseg;

  int compared   = 0;
  int mismatched = 0;
  int lat;

  ram_hex_monitor #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DIGITS(ND), .REFRESH_BITS(4)
  ) dut (
    .clk(clk), .reset(reset), .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_di(host_di), .host_ack(host_ack),
    .host_do(host_do), .view_addr(view_addr), .lz_blank(lz_blank),
    .an(an), .sseg(sseg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic req, input logic we,
                               input logic [AW-1:0] addr, input logic [DW-1:0] di);
    host_req  = req;
    host_we   = we;
    host_addr = addr;
    host_di   = di;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Wait a bounded number of edges for the ack pulse; lat counts edges waited.
  task automatic waitAck(input string tag, output int lat_o);
    lat_o = 0;
    while (host_ack !== 1'b1 && lat_o < 12) begin
      tick(1);
      lat_o++;
    end
    checkOutput({tag, "_ack"}, 32'(host_ack), 32'd1);
  endtask

  task automatic hostTxn(input string tag, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] di, input logic [DW-1:0] exp_do,
                         output int lat_o);
    applyStimulus(1'b1, we, addr, di);
    waitAck(tag, lat_o);
    checkOutput({tag, "_do"}, 32'(host_do), 32'(exp_do));
    applyStimulus(1'b0, 1'b0, addr, di);
    tick(1);
    checkOutput({tag, "_pulse"}, 32'(host_ack), 32'd0);
    checkOutput({tag, "_hold"}, 32'(host_do), 32'(exp_do));
  endtask

  // exp packs the four expected sseg bytes as {digit3, digit2, digit1, digit0}.
  task automatic scanCheck(input string tag, input logic [31:0] exp);
    logic [3:0] prev_an;
    logic [3:0] exp_an;
    int         n;
    bit         found;
    tick(4);
    prev_an = an;
    found   = 1'b0;
    n       = 0;
    while (!found && n < 40) begin
      tick(1);
      n++;
      found   = (an == 4'b1110) && (prev_an != 4'b1110);
      prev_an = an;
    end
    checkOutput({tag, "_sync"}, 32'(found), 32'd1);
    for (int s = 0; s < 16; s++) begin
      if (s > 0) tick(1);
      exp_an = ~(4'b0001 << (s / 4));
      checkOutput($sformatf("%s_an%0d", tag, s), 32'(an), 32'(exp_an));
      checkOutput($sformatf("%s_seg%0d", tag, s), 32'(sseg), 32'(exp[(s/4)*8 +: 8]));
    end
  endtask

  initial begin
    reset     = 1'b1;
    view_addr = '0;
    lz_blank  = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0);

    $display("[TB] reset");
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checkOutput("rst_an", 32'(an), 32'hF);
      checkOutput("rst_sseg", 32'(sseg), 32'hFF);
      checkOutput("rst_ack", 32'(host_ack), 32'd0);
      checkOutput("rst_do", 32'(host_do), 32'd0);
    end

    $display("[TB] write 03 to addr 0 straight out of reset");
    reset = 1'b0;
    hostTxn("wr0", 1'b1, 10'h000, 8'h03, 8'h03, lat);
    checkOutput("wr0_lat", 32'(lat), 32'd2);

    $display("[TB] write A5 to 3FF and read back");
    hostTxn("wr3ff", 1'b1, 10'h3FF, 8'hA5, 8'hA5, lat);
    hostTxn("rd3ff", 1'b0, 10'h3FF, 8'h00, 8'hA5, lat);
    checkOutput("rd3ff_lat", 32'(lat >= 2 && lat <= 3), 32'd1);

    $display("[TB] scan of view_addr 0");
    scanCheck("scan0", {8'hC0, 8'h40, 8'hC0, 8'hB0});

    $display("[TB] view_addr change together with a host read");
    tick(3);
    view_addr = 10'h3FF;
    hostTxn("rd0", 1'b0, 10'h000, 8'h00, 8'h03, lat);
    checkOutput("rd0_lat", 32'(lat), 32'd2);
    scanCheck("scan3ff", {8'h8E, 8'h0E, 8'h88, 8'h92});

    $display("[TB] leading-zero blanking");
    lz_blank  = 1'b1;
    view_addr = 10'h000;
    scanCheck("lz03", {8'hC0, 8'h40, 8'hFF, 8'hB0});
    hostTxn("wr5", 1'b1, 10'h005, 8'h00, 8'h00, lat);
    view_addr = 10'h005;
    scanCheck("lz00", {8'hC0, 8'h12, 8'hFF, 8'hC0});
    lz_blank = 1'b0;

    $display("[TB] reset in the cycle a write is issued");
    applyStimulus(1'b1, 1'b1, 10'h009, 8'h77);
    waitAck("wr9", lat);
    applyStimulus(1'b1, 1'b1, 10'h009, 8'hEE);
    reset = 1'b1;
    tick(1);
    checkOutput("rstw_ack", 32'(host_ack), 32'd0);
    checkOutput("rstw_an", 32'(an), 32'hF);
    checkOutput("rstw_sseg", 32'(sseg), 32'hFF);
    checkOutput("rstw_do", 32'(host_do), 32'd0);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 10'h009, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checkOutput("rstw_noack", 32'(host_ack), 32'd0);
    end
    hostTxn("rd9", 1'b0, 10'h009, 8'h00, 8'h77, lat);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
